// File: rtl/cfg_reply_tx.sv
// cfg_reply_tx: serialises a captured reply (up to RPY_MAX bytes) into
// 9-bit N-Chars for an external output buffer, with an optional CRC-8
// byte and an EOP/EEP terminator. Writes are throttled by full_eobuf_i.
module cfg_reply_tx #(
  parameter int EXT_DW  = 9,
  parameter int RPY_MAX = 12
) (
  input  logic                 gclk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [8*RPY_MAX-1:0] rpy_data_i,
  input  logic [3:0]           rpy_len_i,
  input  logic                 crc_en_i,
  input  logic                 abort_i,
  input  logic                 full_eobuf_i,
  output logic [EXT_DW-1:0]    EXT_data_o,
  output logic                 we_EXTport_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 eep_o,
  output logic                 rejected_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CRC  = 2'd2,
    TERM = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [8*RPY_MAX-1:0] r_data;
  logic [3:0]           r_len;
  logic                 r_crc_en;
  logic [3:0]           r_idx;
  logic [7:0]           r_crc;
  logic                 r_eep;
  logic                 r_done;
  logic                 r_done_eep;
  logic                 r_rej;

  logic                 w_len_ok;
  logic                 w_accept;
  logic                 w_we;
  logic                 w_last;
  logic [7:0]           w_byte;
  logic [8:0]           w_char;

  // CRC-8, poly x^8+x^2+x+1, MSB first, one byte folded per call
  function automatic logic [7:0] crc8_fold(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign w_len_ok = (rpy_len_i != 4'd0) && (int'(rpy_len_i) <= RPY_MAX);
  assign w_accept = (r_state == IDLE) && start_i && w_len_ok;
  assign w_we     = (r_state != IDLE) && !full_eobuf_i;
  assign w_last   = (r_idx == (r_len - 4'd1));
  assign w_byte   = r_data[{r_idx, 3'b000} +: 8];

  // state register
  always_ff @(posedge gclk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // next-state logic; abort wins over the normal SEND/CRC progression
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = SEND;
      SEND: begin
        if (abort_i)           w_next = TERM;
        else if (w_we && w_last) w_next = r_crc_en ? CRC : TERM;
      end
      CRC:  if (abort_i || w_we) w_next = TERM;
      TERM: if (w_we) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // output decode; character depends only on state so it holds while full
  always_comb begin
    w_char = 9'h000;
    case (r_state)
      IDLE:    w_char = 9'h000;
      SEND:    w_char = {1'b0, w_byte};
      CRC:     w_char = {1'b0, r_crc};
      TERM:    w_char = {1'b1, 7'b0, r_eep};
      default: w_char = 9'h000;
    endcase
  end

  assign EXT_data_o   = EXT_DW'(w_char);
  assign we_EXTport_o = w_we;
  assign busy_o       = (r_state != IDLE);
  assign done_o       = r_done;
  assign eep_o        = r_done_eep;
  assign rejected_o   = r_rej;

  // reply capture; payload needs no reset since it is reloaded on every accept
  always_ff @(posedge gclk) begin
    if (w_accept) begin
      r_data   <= rpy_data_i;
      r_len    <= rpy_len_i;
      r_crc_en <= crc_en_i;
    end
  end

  // byte index, running CRC, EEP flag and the one-cycle status pulses
  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      r_idx      <= 4'd0;
      r_crc      <= 8'h00;
      r_eep      <= 1'b0;
      r_done     <= 1'b0;
      r_done_eep <= 1'b0;
      r_rej      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_idx <= 4'd0;
        r_crc <= 8'h00;
        r_eep <= 1'b0;
      end else if ((r_state == SEND) && w_we) begin
        r_idx <= r_idx + 4'd1;
        r_crc <= crc8_fold(r_crc, w_byte);
      end
      if (((r_state == SEND) || (r_state == CRC)) && abort_i) r_eep <= 1'b1;
      r_done     <= (r_state == TERM) && w_we;
      r_done_eep <= (r_state == TERM) && w_we && r_eep;
      r_rej      <= (r_state == IDLE) && start_i && !w_len_ok;
    end
  end

endmodule

// File: tb/tb_cfg_reply_tx.sv
// Directed bench for cfg_reply_tx: logs every accepted N-Char and checks
// packets against hand-computed sequences.
module tb_cfg_reply_tx;

  localparam int EXT_DW  = 9;
  localparam int RPY_MAX = 12;

  logic                 gclk = 1'b0;
  logic                 reset;
  logic                 start_i;
  logic [8*RPY_MAX-1:0] rpy_data_i;
  logic [3:0]           rpy_len_i;
  logic                 crc_en_i;
  logic                 abort_i;
  logic                 full_eobuf_i;
  logic [EXT_DW-1:0]    EXT_data_o;
  logic                 we_EXTport_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 eep_o;
  logic                 rejected_o;

  cfg_reply_tx #(.EXT_DW(EXT_DW), .RPY_MAX(RPY_MAX)) dut (
    .gclk         (gclk),
    .reset        (reset),
    .start_i      (start_i),
    .rpy_data_i   (rpy_data_i),
    .rpy_len_i    (rpy_len_i),
    .crc_en_i     (crc_en_i),
    .abort_i      (abort_i),
    .full_eobuf_i (full_eobuf_i),
    .EXT_data_o   (EXT_data_o),
    .we_EXTport_o (we_EXTport_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .eep_o        (eep_o),
    .rejected_o   (rejected_o)
  );

  always #5 gclk = ~gclk;

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;
  int done_cnt = 0;
  logic [8:0] wq[$];
  int         wc[$];
  logic [8:0] ex[$];

  always @(posedge gclk) cyc_n++;

  // inputs change just after posedge, so the negedge view predicts the next write
  always @(negedge gclk) begin
    if (we_EXTport_o) begin
      wq.push_back(EXT_data_o);
      wc.push_back(cyc_n);
    end
    if (done_o) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic start_pkt(input logic [3:0] len, input logic [95:0] d, input logic ce);
    wq.delete();
    wc.delete();
    tick();
    start_i    = 1'b1;
    rpy_len_i  = len;
    rpy_data_i = d;
    crc_en_i   = ce;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic exp_eep);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (done_o) got = 1'b1;
      else tick();
    end
    chk({tag, " done"}, {31'b0, got}, 32'd1);
    if (got) chk({tag, " eep"}, {31'b0, eep_o}, {31'b0, exp_eep});
  endtask

  task automatic check_q(input string tag, input bit consec);
    chk({tag, " count"}, wq.size(), ex.size());
    for (int i = 0; i < ex.size() && i < wq.size(); i++) begin
      chk($sformatf("%s char%0d", tag, i), {23'b0, wq[i]}, {23'b0, ex[i]});
      if (consec && i > 0) chk($sformatf("%s gap%0d", tag, i), wc[i] - wc[i-1], 32'd1);
    end
  endtask

  initial begin
    logic [95:0] d;
    int dc;
    reset = 1'b1; start_i = 1'b0; rpy_data_i = '0; rpy_len_i = 4'd0;
    crc_en_i = 1'b0; abort_i = 1'b0; full_eobuf_i = 1'b0;
    #12;
    chk("rst data", {23'b0, EXT_data_o}, 32'h0);
    chk("rst we", {31'b0, we_EXTport_o}, 32'd0);
    chk("rst busy", {31'b0, busy_o}, 32'd0);
    chk("rst done", {30'b0, done_o, eep_o}, 32'd0);
    chk("rst rej", {31'b0, rejected_o}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // three bytes, no CRC, back-to-back writes
    start_pkt(4'd3, 96'h332211, 1'b0);
    chk("p1 busy", {31'b0, busy_o}, 32'd1);
    wait_done("p1", 1'b0);
    ex = '{9'h011, 9'h022, 9'h033, 9'h100};
    check_q("p1", 1'b1);

    // "123456789" with CRC-8 check value 0xF4
    d = '0;
    for (int i = 0; i < 9; i++) d[8*i +: 8] = 8'h31 + 8'(i);
    start_pkt(4'd9, d, 1'b1);
    wait_done("p2", 1'b0);
    ex = '{9'h031, 9'h032, 9'h033, 9'h034, 9'h035, 9'h036, 9'h037, 9'h038, 9'h039, 9'h0F4, 9'h100};
    check_q("p2", 1'b1);

    // single byte with CRC, buffer full for 3 cycles after first write
    start_pkt(4'd1, 96'h01, 1'b1);
    tick();
    full_eobuf_i = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("p3 frozen we%0d", i), {31'b0, we_EXTport_o}, 32'd0);
      chk($sformatf("p3 frozen data%0d", i), {23'b0, EXT_data_o}, 32'h007);
      if (i < 2) begin tick(); #1; end
    end
    full_eobuf_i = 1'b0;
    wait_done("p3", 1'b0);
    ex = '{9'h001, 9'h007, 9'h100};
    check_q("p3", 1'b0);

    // abort coinciding with the second byte write
    start_pkt(4'd5, 96'hA4A3A2A1A0, 1'b1);
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    wait_done("p4", 1'b1);
    ex = '{9'h0A0, 9'h0A1, 9'h101};
    check_q("p4", 1'b1);

    // rejected lengths 0 and RPY_MAX+1
    start_pkt(4'd0, 96'h55, 1'b0);
    chk("rej0 pulse", {31'b0, rejected_o}, 32'd1);
    chk("rej0 busy", {31'b0, busy_o}, 32'd0);
    tick();
    chk("rej0 clear", {31'b0, rejected_o}, 32'd0);
    start_pkt(4'd13, 96'h55, 1'b0);
    chk("rej13 pulse", {31'b0, rejected_o}, 32'd1);
    tick();
    chk("rej no write", wq.size(), 32'd0);

    // start while busy is ignored
    start_pkt(4'd4, 96'h44434241, 1'b0);
    start_i = 1'b1; rpy_len_i = 4'd2; rpy_data_i = 96'hEEFF;
    tick();
    start_i = 1'b0;
    chk("busy start rej", {31'b0, rejected_o}, 32'd0);
    wait_done("p5", 1'b0);
    ex = '{9'h041, 9'h042, 9'h043, 9'h044, 9'h100};
    check_q("p5", 1'b1);

    // reset after the second byte, then a full RPY_MAX packet
    start_pkt(4'd5, 96'h5554535251, 1'b1);
    tick();
    tick();
    dc = done_cnt;
    reset = 1'b1;
    #1;
    chk("mid rst data", {23'b0, EXT_data_o}, 32'h0);
    chk("mid rst we", {31'b0, we_EXTport_o}, 32'd0);
    chk("mid rst busy", {31'b0, busy_o}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("mid rst no done", done_cnt - dc, 32'd0);
    ex = '{9'h051, 9'h052};
    check_q("p6", 1'b1);
    d = '0;
    for (int i = 0; i < 12; i++) d[8*i +: 8] = 8'h60 + 8'(i);
    start_pkt(4'd12, d, 1'b0);
    wait_done("p7", 1'b0);
    ex.delete();
    for (int i = 0; i < 12; i++) ex.push_back({1'b0, 8'h60 + 8'(i)});
    ex.push_back(9'h100);
    check_q("p7", 1'b1);

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cfg_reply_tx.md
CFG_REPLY_TX -- requirements
Module: cfg_reply_tx

Interface
REQ-001 SHALL have parameter EXT_DW, default 9, width of N-Char written to the external output buffer (bit 8 = control flag).
REQ-002 SHALL have parameter RPY_MAX, default 12, maximum reply length in bytes.
REQ-003 SHALL have port gclk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start_i  input  1  one-cycle request to send a reply packet.
REQ-006 SHALL have port rpy_data_i  input  8*RPY_MAX  reply bytes; byte k = bits [8k+7:8k], byte 0 sent first.
REQ-007 SHALL have port rpy_len_i  input  4  number of reply bytes, valid 1..RPY_MAX.
REQ-008 SHALL have port crc_en_i  input  1  append CRC-8 byte before terminator.
REQ-009 SHALL have port abort_i  input  1  terminate current packet with EEP.
REQ-010 SHALL have port full_eobuf_i  input  1  external output buffer full.
REQ-011 SHALL have port EXT_data_o  output  EXT_DW  N-Char to external output buffer.
REQ-012 SHALL have port we_EXTport_o  output  1  write strobe; one N-Char accepted per high cycle.
REQ-013 SHALL have port busy_o  output  1  packet in progress.
REQ-014 SHALL have port done_o  output  1  one-cycle pulse after terminator written.
REQ-015 SHALL have port eep_o  output  1  qualifies done_o: packet ended with EEP.
REQ-016 SHALL have port rejected_o  output  1  one-cycle pulse, start refused.

Function
REQ-017 SHALL implement states IDLE, SEND, CRC, TERM; one-hot or binary encoding is free.
REQ-018 SHALL, in IDLE on start_i with 1<=rpy_len_i<=RPY_MAX, capture rpy_data_i, rpy_len_i, crc_en_i, clear byte index and CRC register to 0x00, go to SEND.
REQ-019 SHALL, in IDLE on start_i with rpy_len_i=0 or >RPY_MAX, stay IDLE and pulse rejected_o next cycle.
REQ-020 SHALL ignore start_i while busy_o=1 (no capture, no rejected_o).
REQ-021 SHALL drive we_EXTport_o = (state!=IDLE) AND NOT full_eobuf_i; a character advances only on cycles with we_EXTport_o=1.
REQ-022 SHALL, in SEND, present {1'b0, byte[index]}; on write increment index and fold byte into CRC; after byte rpy_len-1 go to CRC if crc_en captured, else TERM.
REQ-023 SHALL compute CRC-8 poly 0x07 (x^8+x^2+x+1), init 0x00, MSB-first, no reflection, no final XOR, over all reply bytes only.
REQ-024 SHALL, in CRC, present {1'b0, crc}; on write go to TERM.
REQ-025 SHALL, in TERM, present EOP = 9'b1_0000_0000; on write go to IDLE, pulse done_o next cycle with eep_o=0.
REQ-026 SHALL, on abort_i in SEND or CRC, go to TERM with EEP flag set; TERM then presents EEP = 9'b1_0000_0001 and done_o pulses with eep_o=1.
REQ-027 SHALL, if abort_i coincides with a write in SEND/CRC, accept that character, then go to TERM with EEP.
REQ-028 SHALL ignore abort_i in IDLE and TERM.
REQ-029 SHALL hold EXT_data_o and state stable while full_eobuf_i=1; no character lost or duplicated.
REQ-030 SHALL drive EXT_data_o = 0 in IDLE; busy_o = (state!=IDLE).
REQ-031 SHALL give latency: start_i sampled at edge N -> first we_EXTport_o possible in cycle after N; back-to-back packets allowed (start_i accepted in cycle after done_o... i.e. once state is IDLE).

Reset
REQ-032 SHALL, while reset=1 (asynchronous), force IDLE, index 0, CRC 0x00, EEP flag 0, EXT_data_o=0, we_EXTport_o=0, busy_o=0, done_o=0, eep_o=0, rejected_o=0.
REQ-033 SHALL, on reset mid-packet, abandon the packet with no terminator and no done_o.

Verification
REQ-034 SHALL pass: len=3 bytes 0x11,0x22,0x33, crc_en=0, full=0 -> writes 0x011,0x022,0x033,0x100 on 4 consecutive cycles, done_o=1 eep_o=0.
REQ-035 SHALL pass: len=9 bytes ASCII "123456789", crc_en=1 -> 9 data writes, then 0x0F4, then 0x100.
REQ-036 SHALL pass: len=1 byte 0x01, crc_en=1, full_eobuf_i high 3 cycles after first write -> writes 0x001, 0x007, 0x100; outputs frozen while full.
REQ-037 SHALL pass: len=5, abort_i with 2nd byte write -> writes byte0, byte1, 0x101; done_o with eep_o=1.
REQ-038 SHALL pass: start_i with len=0 -> rejected_o pulse, no write; start_i during busy -> ignored, packet unchanged.
REQ-039 SHALL pass: reset asserted after 2nd byte -> outputs zero immediately, no EOP/EEP, next start sends full new packet.
